kbd_ctrl: RTL

PS/2 keyboard receiver with a memory-mapped read interface. It feeds the MMU's keyboard read path: its `dout` connects to `dout_kbd`, and it is selected by `sel_kbd`. It samples `PS2_CLK`/`PS2_DAT`, deframes 11-bit PS/2 frames, checks them, and buffers good scancodes in a FIFO. The CPU pops scancodes or reads status through load instructions.

---
 rtl/kbd_ctrl_if.sv | 10 +
 rtl/kbd_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/kbd_ctrl_if.sv
// rtl/kbd_ctrl_if.sv - MMU read-bus bundle for the PS/2 keyboard controller
interface kbd_ctrl_if;
  logic        sel;
  logic        re;
  logic [31:0] addr;
  logic [31:0] dout;

  modport master (output sel, re, addr, input dout);
  modport slave  (input sel, re, addr, output dout);
endinterface

// File: rtl/kbd_ctrl.sv
// rtl/kbd_ctrl.sv - PS/2 keyboard receiver: sync, deframe, check, scancode FIFO, DATA/STATUS regs
module kbd_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_AW        = 3,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  kbd_ctrl_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

  state_t             r_state;
  logic [2:0]         r_clk_sync;
  logic [2:0]         r_dat_sync;
  logic [3:0]         r_bitcnt;
  logic [9:0]         r_shreg;
  logic [TW-1:0]      r_tcnt;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_overflow;
  logic               r_frame_err;

  logic        w_fall, w_dat, w_empty, w_full, w_good, w_push, w_push_ok;
  logic        w_timeout, w_pop, w_stat_rd, w_ovf_set, w_ferr_set, w_unused;
  logic [3:0]  w_count4;
  logic [31:0] w_dout;

  assign w_fall    = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_dat     = r_dat_sync[1];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign w_good    = (^r_shreg[8:0]) & r_shreg[9];
  assign w_push    = (r_state == S_CHECK) & w_good;
  assign w_timeout = (r_state == S_RECV) & ~w_fall & (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
  assign w_pop      = bus.sel & bus.re & ~bus.addr[2] & ~w_empty;
  assign w_stat_rd  = bus.sel & bus.re & bus.addr[2];
  assign w_push_ok  = w_push & (~w_full | w_pop);
  assign w_ovf_set  = w_push & w_full & ~w_pop;
  assign w_ferr_set = ((r_state == S_CHECK) & ~w_good) | w_timeout;
  assign w_count4   = 4'(r_count);
  assign w_unused   = ^{bus.addr[31:3], bus.addr[1:0]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_clk_sync  <= 3'b111;
      r_dat_sync  <= 3'b111;
      r_bitcnt    <= '0;
      r_shreg     <= '0;
      r_tcnt      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[1:0], ps2_dat};

      case (r_state)
        S_IDLE: begin
          if (w_fall && !w_dat) begin
            r_state  <= S_RECV;
            r_bitcnt <= '0;
            r_tcnt   <= '0;
          end
        end
        S_RECV: begin
          if (w_fall) begin
            r_shreg[r_bitcnt] <= w_dat;
            r_tcnt            <= '0;
            if (r_bitcnt == 4'd9) r_state <= S_CHECK;
            else                  r_bitcnt <= r_bitcnt + 4'd1;
          end else if (w_timeout) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_tcnt   <= '0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        S_CHECK: begin
          r_state  <= S_IDLE;
          r_bitcnt <= '0;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= r_shreg[7:0];
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Setting wins over the clear-on-read of STATUS
      r_overflow  <= w_ovf_set  | (r_overflow  & ~w_stat_rd);
      r_frame_err <= w_ferr_set | (r_frame_err & ~w_stat_rd);
    end
  end

  always_comb begin
    w_dout = '0;
    if (bus.addr[2])
      w_dout = {20'b0, w_count4, 4'b0, r_frame_err, r_overflow, w_full, ~w_empty};
    else if (!w_empty)
      w_dout = {23'b0, 1'b1, r_mem[r_rd_ptr]};
  end

  assign bus.dout = w_dout;
endmodule
